updown_mod_counter: RTL
=======================

// Module: updown_mod_counter
//
// PURPOSE
//   Parametrised up/down counter with a runtime-programmable top value and
//   synchronous load. Selectable wrap or saturate at the limits, plus a
//   registered wrap pulse. Replaces the fixed down_counter wherever timers,
//   dividers or index generators need a direction, modulus or preset.
//
// PARAMETERS
//   N             3   counter width in bits (N >= 1)
//   WRAP_MODE     1   1 = wrap at limits; 0 = saturate (hold) at limits
//   RESET_TO_MAX  1   1 = reset loads max_value; 0 = reset loads 0
//
// PORTS
//   clock       in   1   rising-edge clock, sole clock domain
//   reset       in   1   synchronous, active-low reset (sampled on clock rise)
//   enable      in   1   count step qualifier
//   dir         in   1   1 = count up, 0 = count down
//   load        in   1   synchronous load strobe
//   load_value  in   N   value to load
//   max_value   in   N   inclusive top of count range [0..max_value]
//   count       out  N   registered counter value
//   wrap        out  1   registered 1-cycle pulse: a wrap occurred on the last edge
//   at_limit    out  1   combinational: count at the terminal value for dir
//
// BEHAVIOUR
//   - All state updates occur on the rising edge of clock.
//   - Priority per edge: reset (low) > load > enable > hold.
//   - Reset: count <= (RESET_TO_MAX ? max_value : 0); wrap <= 0.
//   - Load: count <= min(load_value, max_value); wrap <= 0.
//     - Load wins over enable in the same cycle.
//   - Enable, dir=1:
//     - count < max_value -> count+1.
//     - count == max_value -> wrap mode: 0 with wrap<=1; saturate: hold, wrap<=0.
//   - Enable, dir=0:
//     - count > 0 -> count-1.
//     - count == 0 -> wrap mode: max_value with wrap<=1; saturate: hold, wrap<=0.
//   - Out of range: if max_value drops below count, the next enabled step sets
//     count <= max_value in either dir, with wrap <= 0.
//   - max_value == 0:
//     - count stays 0.
//     - Wrap mode: wrap=1 on every enabled step.
//   - No step (enable=0, no load): count holds; wrap <= 0.
//     - wrap is never high two cycles unless a wrap occurs on each edge.
//   - at_limit = dir ? (count >= max_value) : (count == 0).
//     - Combinational from count/dir/max_value; no added latency.
//   - Arithmetic is N-bit unsigned; no carry or borrow escapes.
//     - Wrap is decided by compare, never by natural overflow.
//     - Behaviour is identical for max_value = 2^N-1.
//   - dir may change on any cycle; it takes effect on the same edge.
//   - Reset asserted mid-count overrides load/enable on that edge.
//
// TESTING
//   1. N=3, RESET_TO_MAX=1, max=7, reset low 1 clk, dir=0, enable=1
//      -> count 7,6,..,0,7; wrap=1 only in the cycle after 0->7.
//   2. WRAP_MODE=0, max=5, dir=1 from 0, 8 enabled clks
//      -> count 1..5 then holds 5; wrap stays 0; at_limit=1 at 5.
//   3. count=3, load=1 with load_value=6, max=4, enable=1 same cycle
//      -> count=4 next cycle (load clamps and wins); wrap=0.
//   4. Counting up at 6 with max=7, then max changed to 2 with enable=1
//      -> count=2 next edge, wrap=0; next up step -> 0 with wrap=1.
//   5. Mid-count at 4, reset low with load=1 and enable=1
//      -> count=max_value (RESET_TO_MAX=1), wrap=0.
//      -> Repeat with RESET_TO_MAX=0 -> count=0.
//   6. max=0, wrap mode, enable=1 for 3 clks -> count=0 and wrap=1 each cycle.

Source files
------------

// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Up/down counter over the inclusive range [0..max_value], where max_value
//   can change at runtime. The counter supports a synchronous load that is
//   clamped to max_value. At the limits it either wraps or saturates, chosen
//   by a parameter. A registered wrap pulse marks every edge on which a wrap
//   took place.
//
//   Priority on each rising edge: reset (low) > load > enable > hold.
//
//   All limit decisions compare against max_value and 0. They never rely on
//   natural N-bit overflow, so max_value = 2^N-1 behaves the same as any
//   other top value.
module updown_mod_counter #(
   parameter int N            = 3,
   parameter bit WRAP_MODE    = 1'b1,
   parameter bit RESET_TO_MAX = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   input  logic         dir,
   input  logic         load,
   input  logic [N-1:0] load_value,
   input  logic [N-1:0] max_value,
   output logic [N-1:0] count,
   output logic         wrap,
   output logic         at_limit
);

   localparam logic [N-1:0] ONE  = N'(1);
   localparam logic [N-1:0] ZERO = '0;

   // Compare results shared by the next-state logic and at_limit.
   logic         above_max;
   logic         at_top;
   logic         at_bottom;
   logic [N-1:0] load_clamped;

   // Next-state values chosen by the step logic below.
   logic [N-1:0] count_next;
   logic         wrap_next;

   assign above_max    = (count > max_value);
   assign at_top       = (count == max_value);
   assign at_bottom    = (count == ZERO);
   assign load_clamped = (load_value > max_value) ? max_value : load_value;

   // Terminal value for the current direction. This is purely combinational,
   // so a change of dir or max_value shows up without a cycle of delay.
   assign at_limit = dir ? (count >= max_value) : at_bottom;

   // Next count and wrap pulse for a non-reset edge.
   always_comb begin
      count_next = count;
      wrap_next  = 1'b0;
      if (load) begin
         count_next = load_clamped;
      end else if (enable) begin
         if (above_max) begin
            // max_value shrank below count: snap to the new top, with no pulse.
            count_next = max_value;
         end else if (dir) begin
            if (!at_top) begin
               count_next = count + ONE;
            end else if (WRAP_MODE) begin
               count_next = ZERO;
               wrap_next  = 1'b1;
            end
         end else begin
            if (!at_bottom) begin
               count_next = count - ONE;
            end else if (WRAP_MODE) begin
               count_next = max_value;
               wrap_next  = 1'b1;
            end
         end
      end
   end

   // Count and wrap registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= RESET_TO_MAX ? max_value : ZERO;
         wrap  <= 1'b0;
      end else begin
         count <= count_next;
         wrap  <= wrap_next;
      end
   end

endmodule
